// File: rtl/sequencer_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_reorder_buf
// Description : Write-reordering buffer for the crossbar return path. Tagged
//               write data lands in a compacting buffer; a tag queue loaded in
//               issue order selects which word is released next (oldest
//               matching entry wins). Registered valid/ready output, sticky
//               overflow flags for both the buffer and the tag queue.
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer_reorder_buf #(
    parameter int TAG_WIDTH      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int BUF_DEPTH_POW  = 3,
    parameter int TAGQ_DEPTH_POW = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [DATA_WIDTH-1:0]    wrdata_bi,
    input  logic [TAG_WIDTH-1:0]     wrtag_i,
    output logic                     wr_ready_o,
    output logic                     tag_fifo_full,
    input  logic                     tag_fifo_wrreq,
    input  logic [TAG_WIDTH-1:0]     tag_fifo_wdata,
    output logic                     wr_o,
    output logic [DATA_WIDTH-1:0]    wrdata_bo,
    input  logic                     rd_ready_i,
    output logic [BUF_DEPTH_POW:0]   occupancy_o,
    output logic                     err_buf_ovf_o,
    output logic                     err_tag_ovf_o
);

    localparam int c_BUF_DEPTH = 1 << BUF_DEPTH_POW;
    localparam int c_TQ_DEPTH  = 1 << TAGQ_DEPTH_POW;
    localparam int c_OCC_W     = BUF_DEPTH_POW + 1;
    localparam int c_TQC_W     = TAGQ_DEPTH_POW + 1;
    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(c_BUF_DEPTH);
    localparam logic [c_TQC_W-1:0] c_TQ_FULL  = c_TQC_W'(c_TQ_DEPTH);

    // Data buffer: entries 0..r_occ-1 valid, index 0 is the oldest.
    logic [DATA_WIDTH-1:0]     r_buf_data [c_BUF_DEPTH];
    logic [TAG_WIDTH-1:0]      r_buf_tag  [c_BUF_DEPTH];
    logic [c_OCC_W-1:0]        r_occ;

    // Tag queue (circular FIFO).
    logic [TAG_WIDTH-1:0]      r_tq_mem [c_TQ_DEPTH];
    logic [TAGQ_DEPTH_POW-1:0] r_tq_rd;
    logic [TAGQ_DEPTH_POW-1:0] r_tq_wr;
    logic [c_TQC_W-1:0]        r_tq_cnt;

    // Output slot and sticky errors.
    logic                      r_wr_o;
    logic [DATA_WIDTH-1:0]     r_wrdata;
    logic                      r_err_buf;
    logic                      r_err_tag;

    logic [c_BUF_DEPTH-1:0]    w_hit;
    logic                      w_any_hit;
    logic [BUF_DEPTH_POW-1:0]  w_k;
    logic [c_OCC_W-1:0]        w_k_ext;
    logic [TAG_WIDTH-1:0]      w_head;
    logic                      w_tq_empty;
    logic                      w_slot_free;
    logic                      w_match;
    logic                      w_buf_full;
    logic                      w_wr_acc;
    logic                      w_push_acc;
    logic [c_OCC_W-1:0]        w_app_idx;

    assign w_head      = r_tq_mem[r_tq_rd];
    assign w_tq_empty  = (r_tq_cnt == '0);
    assign w_slot_free = !r_wr_o || rd_ready_i;
    assign w_buf_full  = (r_occ >= c_OCC_FULL);
    assign w_wr_acc    = wr_i && !w_buf_full;
    assign w_push_acc  = tag_fifo_wrreq && !tag_fifo_full;
    // A hit implies the buffer is non-empty, so no separate occupancy test.
    assign w_match     = w_slot_free && !w_tq_empty && w_any_hit;
    assign w_k_ext     = {1'b0, w_k};
    // Append lands just above the surviving entries after any removal.
    assign w_app_idx   = r_occ - {{BUF_DEPTH_POW{1'b0}}, w_match};

    // Per-entry tag compare against the queue head, valid entries only.
    for (genvar gi = 0; gi < c_BUF_DEPTH; gi++) begin : g_hit
        assign w_hit[gi] = (c_OCC_W'(gi) < r_occ) && (r_buf_tag[gi] == w_head);
    end

    // Lowest-index hit wins so duplicates release oldest-first.
    always_comb begin
        w_any_hit = 1'b0;
        w_k       = '0;
        for (int i = c_BUF_DEPTH - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit = 1'b1;
                w_k       = BUF_DEPTH_POW'(i);
            end
        end
    end

    // Buffer storage: compact over the removed entry, then append.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_tag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                if (w_wr_acc && (w_app_idx == c_OCC_W'(i))) begin
                    r_buf_data[i] <= wrdata_bi;
                    r_buf_tag[i]  <= wrtag_i;
                end else if (w_match && (c_OCC_W'(i) >= w_k_ext) && (i != c_BUF_DEPTH - 1)) begin
                    r_buf_data[i] <= r_buf_data[(i + 1) % c_BUF_DEPTH];
                    r_buf_tag[i]  <= r_buf_tag[(i + 1) % c_BUF_DEPTH];
                end
            end
        end
    end

    // Occupancy: +1 on accepted write, -1 on release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + {{BUF_DEPTH_POW{1'b0}}, w_wr_acc} - {{BUF_DEPTH_POW{1'b0}}, w_match};
        end
    end

    // Tag queue: push at write pointer, pop on every release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < c_TQ_DEPTH; i++) begin
                r_tq_mem[i] <= '0;
            end
            r_tq_rd  <= '0;
            r_tq_wr  <= '0;
            r_tq_cnt <= '0;
        end else begin
            if (w_push_acc) begin
                r_tq_mem[r_tq_wr] <= tag_fifo_wdata;
                r_tq_wr           <= r_tq_wr + 1'b1;
            end
            if (w_match) begin
                r_tq_rd <= r_tq_rd + 1'b1;
            end
            r_tq_cnt <= r_tq_cnt + {{TAGQ_DEPTH_POW{1'b0}}, w_push_acc}
                                 - {{TAGQ_DEPTH_POW{1'b0}}, w_match};
        end
    end

    // Output slot: load on match, clear when free and idle, hold when stalled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_o   <= 1'b0;
            r_wrdata <= '0;
        end else if (w_match) begin
            r_wr_o   <= 1'b1;
            r_wrdata <= r_buf_data[w_k];
        end else if (w_slot_free) begin
            r_wr_o   <= 1'b0;
            r_wrdata <= '0;
        end
    end

    // Sticky overflow flags, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err_buf <= 1'b0;
            r_err_tag <= 1'b0;
        end else begin
            if (wr_i && w_buf_full) begin
                r_err_buf <= 1'b1;
            end
            if (tag_fifo_wrreq && tag_fifo_full) begin
                r_err_tag <= 1'b1;
            end
        end
    end

    assign wr_ready_o    = !w_buf_full;
    assign tag_fifo_full = (r_tq_cnt >= c_TQ_FULL);
    assign occupancy_o   = r_occ;
    assign wr_o          = r_wr_o;
    assign wrdata_bo     = r_wrdata;
    assign err_buf_ovf_o = r_err_buf;
    assign err_tag_ovf_o = r_err_tag;

endmodule
`default_nettype wire

// File: doc/sequencer_reorder_buf.md
# sequencer_reorder_buf

Parametrised write-reordering buffer for the crossbar return path. Tagged write data arrives in any order and is held in a compacting buffer. A tag queue, loaded by the arbiter in issue order, sets the release order. The block releases each data word only when its tag reaches the head of the tag queue, searching the whole buffer with the oldest entry winning. The output has valid/ready backpressure, and both overflows are reported as sticky error flags.

## Interface
- TAG_WIDTH, 2, tag bit width
- DATA_WIDTH, 32, data bit width
- BUF_DEPTH_POW, 3, data buffer holds 2**BUF_DEPTH_POW entries
- TAGQ_DEPTH_POW, 3, tag queue holds 2**TAGQ_DEPTH_POW tags

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low; all state cleared while low
- wr_i  in  1  write strobe for tagged data
- wrdata_bi  in  DATA_WIDTH  write data
- wrtag_i  in  TAG_WIDTH  tag of write data
- wr_ready_o  out  1  buffer has space (occupancy < 2**BUF_DEPTH_POW)
- tag_fifo_full  out  1  tag queue full
- tag_fifo_wrreq  in  1  push tag into queue
- tag_fifo_wdata  in  TAG_WIDTH  tag to push
- wr_o  out  1  output valid (registered)
- wrdata_bo  out  DATA_WIDTH  output data (registered)
- rd_ready_i  in  1  downstream accepts wr_o/wrdata_bo this cycle
- occupancy_o  out  BUF_DEPTH_POW+1  current buffer entry count
- err_buf_ovf_o  out  1  sticky: a write was dropped because the buffer was full
- err_tag_ovf_o  out  1  sticky: a tag push was dropped because the queue was full

## Operation
- Buffer: entries 0..occupancy-1 are valid, and index 0 is the oldest. Removing entry k shifts entries k+1..top down by one.
- Tag queue: circular FIFO with registered read pointer, write pointer and count. The head tag is visible while count > 0.
- Output slot free means wr_o==0, or wr_o==1 with rd_ready_i==1.
- Match cycle: the slot must be free, the tag queue non-empty and the buffer non-empty.
  - Compare the head tag against every valid entry. The lowest matching index k wins.
  - On a match: load wr_o=1 and wrdata_bo=entry[k], pop the tag queue, remove entry k.
  - With no match, nothing changes.
- Slot free with no match: wr_o becomes 0 and wrdata_bo becomes 0.
- Slot not free (wr_o==1, rd_ready_i==0): wr_o and wrdata_bo hold, and no match is attempted.
- Write: accepted iff occupancy < 2**BUF_DEPTH_POW at the start of the cycle.
  - The new entry is appended at index (occupancy minus any same-cycle removal).
  - Removal and append in the same cycle leave occupancy unchanged.
  - If the buffer is full, the write is dropped and err_buf_ovf_o is set. A same-cycle removal does not rescue it.
- Tag push: accepted iff tag_fifo_full==0 at the start of the cycle. A same-cycle pop does not rescue a push into a full queue; that push is dropped and err_tag_ovf_o is set.
- A push and a pop together on a non-full queue leave the count unchanged. Pointers wrap modulo 2**TAGQ_DEPTH_POW.
- No bypass: a write or tag arriving in cycle t takes part in matching no earlier than cycle t+1.
- Duplicate tags in the buffer are legal; the oldest entry is released first.
- A head tag with no matching entry stalls the output indefinitely; this is not an error.
- The error flags clear only on reset.

## Timing
- Reset (rst_i low, asynchronous assert), all of these take effect immediately:
  - wr_o=0, wrdata_bo=0, occupancy_o=0, wr_ready_o=1
  - tag_fifo_full=0, err_buf_ovf_o=0, err_tag_ovf_o=0
  - buffer and tag queue emptied
- Reset release is sampled at clk_i; the first state update follows the first rising edge with rst_i high.
- Reset mid-operation discards all buffered data and tags, including a wr_o held under backpressure.
- Latency: data at t and tag at t (or earlier), with an idle output, give wr_o=1 at t+2.
- Throughput: one word per cycle while rd_ready_i=1 and matches exist.
- wr_ready_o, tag_fifo_full and occupancy_o are functions of registered state only; none of them combinationally depends on inputs.
- occupancy_o arithmetic is BUF_DEPTH_POW+1 bits wide. It never exceeds 2**BUF_DEPTH_POW and never underflows.

## Test plan
- In-order: push tags 0,1,2,3; write data 0xA0..0xA3 with tags 0..3 → wr_o=1 on four consecutive cycles with 0xA0,0xA1,0xA2,0xA3, first at 2 cycles after the first write/tag.
- Reverse arrival with an entry at index 6: push tags 0..3 and write tags 3,2,1,0 (data 0xD3..0xD0) behind 3 dummy entries with tag 1 → output sequence 0xD0, then the oldest tag-1 dummy, then the rest in tag-queue order. This checks the full-depth search.
- Backpressure: rd_ready_i=0 for 5 cycles with wr_o=1, data 0x55 → wr_o and wrdata_bo hold 0x55, the tag queue is not popped, occupancy is unchanged. After rd_ready_i=1, the next word follows the next cycle.
- Buffer overflow: 8 writes with no tags, then a 9th write (0xFF) → wr_ready_o=0 after the 8th, 0xFF dropped, err_buf_ovf_o=1, occupancy_o=8.
- Tag overflow plus simultaneous pop/push: fill the tag queue with 8 tags, then push again → dropped, err_tag_ovf_o=1. In a non-full steady stream, push and pop in the same cycle → count constant.
- Reset mid-stream: rst_i low while occupancy=5 and wr_o=1 → all outputs at reset values immediately, with no output after release until new tags and data arrive.
